// File: rtl/gd_pkg.sv
// Shared types and fixed-point helpers for the SGD update engine.
// Helpers work on MAX_W-bit words; callers pass the real word width.
package gd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } gd_state_t;

  // Widest word the helpers support, and its full product width.
  localparam int MAX_W  = 32;
  localparam int PROD_W = 2 * MAX_W;

  typedef logic signed [MAX_W-1:0]  word_t;
  typedef logic signed [PROD_W-1:0] prod_t;

  // Keep the low w bits, sign-extended back to full width.
  function automatic prod_t wrap_to(
    input prod_t x,
    input int    w
  );
    return (x <<< (PROD_W - w)) >>> (PROD_W - w);
  endfunction

  function automatic prod_t sat_to(
    input  prod_t x,
    input  int    w,
    output logic  sat
  );
    prod_t hi;
    prod_t lo;
    prod_t r;
    hi  = (prod_t'(1) <<< (w - 1)) - prod_t'(1);
    lo  = ~hi;
    sat = 1'b0;
    r   = x;
    if (x > hi) begin
      r   = hi;
      sat = 1'b1;
    end else if (x < lo) begin
      r   = lo;
      sat = 1'b1;
    end
    return r;
  endfunction

  // (a * b) >>> frac, floor rounding, wrapped to w bits.
  function automatic word_t fxp_scale_mul(
    input word_t a,
    input word_t b,
    input int    w,
    input int    frac
  );
    prod_t p;
    p = (prod_t'(a) * prod_t'(b)) >>> frac;
    return word_t'(wrap_to(p, w));
  endfunction

  function automatic word_t fxp_scale_mul_sat(
    input  word_t a,
    input  word_t b,
    input  int    w,
    input  int    frac,
    output logic  sat
  );
    prod_t p;
    prod_t r;
    p = (prod_t'(a) * prod_t'(b)) >>> frac;
    r = sat_to(p, w, sat);
    return word_t'(r);
  endfunction

  function automatic word_t fxp_sub(
    input word_t a,
    input word_t b,
    input int    w
  );
    return word_t'(wrap_to(prod_t'(a) - prod_t'(b), w));
  endfunction

  function automatic word_t fxp_sub_sat(
    input  word_t a,
    input  word_t b,
    input  int    w,
    output logic  sat
  );
    prod_t r;
    r = sat_to(prod_t'(a) - prod_t'(b), w, sat);
    return word_t'(r);
  endfunction

endpackage

// File: rtl/gd_lane.sv
// One lane of the update datapath: stage 1 = scaled gradient, stage 2 = W - p.
// Ports: en1_i/en2_i load each stage; sat_o only with GD_SATURATE_EN.
module gd_lane
  import gd_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int FRAC  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en1_i,
  input  logic             en2_i,
  input  logic [WIDTH-1:0] lr_i,
  input  logic [WIDTH-1:0] w_i,
  input  logic [WIDTH-1:0] grad_i,
  output logic [WIDTH-1:0] w_new_o
`ifdef GD_SATURATE_EN
  ,
  output logic             sat_o
`endif
);

  logic [WIDTH-1:0] p_q, p_d;
  logic [WIDTH-1:0] w1_q;
  logic [WIDTH-1:0] res_q, res_d;
  word_t gx, lx, wx, px;

  assign gx = word_t'($signed(grad_i));
  assign lx = word_t'($signed(lr_i));
  assign wx = word_t'($signed(w1_q));
  assign px = word_t'($signed(p_q));

`ifdef GD_SATURATE_EN
  logic s1_q, s1_d;
  logic s2_q, s2_d;
  logic sub_sat;

  always_comb begin
    s1_d    = 1'b0;
    sub_sat = 1'b0;
    p_d     = WIDTH'(fxp_scale_mul_sat(gx, lx, WIDTH, FRAC, s1_d));
    res_d   = WIDTH'(fxp_sub_sat(wx, px, WIDTH, sub_sat));
    s2_d    = s1_q | sub_sat;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      if (en1_i) s1_q <= s1_d;
      if (en2_i) s2_q <= s2_d;
    end
  end

  assign sat_o = s2_q;
`else
  always_comb begin
    p_d   = WIDTH'(fxp_scale_mul(gx, lx, WIDTH, FRAC));
    res_d = WIDTH'(fxp_sub(wx, px, WIDTH));
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_q   <= '0;
      w1_q  <= '0;
      res_q <= '0;
    end else begin
      if (en1_i) begin
        p_q  <= p_d;
        w1_q <= w_i;
      end
      if (en2_i) res_q <= res_d;
    end
  end

  assign w_new_o = res_q;

endmodule

// File: rtl/gradient_descent_array.sv
// Batched SGD engine: W_new = W_old - lr*grad on LANES lanes, 2-stage pipe.
// Ports: start/num/lr command, valid/ready in and out, last/busy/done status;
// sat_flag_out is present only when GD_SATURATE_EN is defined.
module gradient_descent_array
  import gd_pkg::*;
#(
  parameter int LANES = 4,
  parameter int WIDTH = 16,
  parameter int FRAC  = 8,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_in,
  input  logic [CNT_W-1:0]       num_updates_in,
  input  logic [WIDTH-1:0]       lr_in,
  input  logic                   valid_in,
  output logic                   ready_out,
  input  logic [LANES*WIDTH-1:0] w_old_in,
  input  logic [LANES*WIDTH-1:0] grad_in,
  output logic                   valid_out,
  input  logic                   ready_in,
  output logic [LANES*WIDTH-1:0] w_new_out,
  output logic                   last_out,
  output logic                   busy_out,
  output logic                   done_out
`ifdef GD_SATURATE_EN
  ,
  output logic [LANES-1:0]       sat_flag_out
`endif
);

  gd_state_t        state_q, state_d;
  logic [WIDTH-1:0] lr_q, lr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] out_q, out_d;
  logic             v1_q, v1_d;
  logic             v2_q, v2_d;
  logic             stall, adv;
  logic             in_fire, out_fire;

  // Only a full, blocked stage 2 stalls; an empty one always refills.
  assign stall    = v2_q & ~ready_in;
  assign adv      = ~stall;
  assign ready_out = (state_q == RUN) && (acc_q < cnt_q) && !stall;
  assign in_fire  = valid_in & ready_out;
  assign out_fire = v2_q & ready_in;

  assign valid_out = v2_q;
  assign last_out  = v2_q && (out_q == cnt_q - CNT_W'(1));
  assign busy_out  = (state_q != IDLE);
  assign done_out  = (state_q == DONE);

  always_comb begin
    state_d = state_q;
    lr_d    = lr_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    out_d   = out_q;
    v1_d    = adv ? in_fire : v1_q;
    v2_d    = adv ? v1_q : v2_q;
    if (in_fire) acc_d = acc_q + CNT_W'(1);
    if (out_fire) out_d = out_q + CNT_W'(1);
    unique case (state_q)
      IDLE: begin
        if (start_in) begin
          lr_d    = lr_in;
          cnt_d   = num_updates_in;
          acc_d   = '0;
          out_d   = '0;
          state_d = (num_updates_in == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (acc_q == cnt_q) state_d = DRAIN;
      end
      DRAIN: begin
        if (!v1_q && !v2_q) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      lr_q    <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      out_q   <= '0;
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      lr_q    <= lr_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
      v1_q    <= v1_d;
      v2_q    <= v2_d;
    end
  end

`ifdef GD_SATURATE_EN
  logic [LANES-1:0] sat_raw;
  assign sat_flag_out = v2_q ? sat_raw : '0;
`endif

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    gd_lane #(
      .WIDTH(WIDTH),
      .FRAC (FRAC)
    ) u_lane (
      .clk    (clk),
      .rst    (rst),
      .en1_i  (adv),
      .en2_i  (adv),
      .lr_i   (lr_q),
      .w_i    (w_old_in[i*WIDTH +: WIDTH]),
      .grad_i (grad_in[i*WIDTH +: WIDTH]),
      .w_new_o(w_new_out[i*WIDTH +: WIDTH])
`ifdef GD_SATURATE_EN
      ,
      .sat_o  (sat_raw[i])
`endif
    );
  end

endmodule

// File: tb/tb_gradient_descent_array.sv
// Scoreboard bench for gradient_descent_array (Q8.8, 4 lanes).
// Driver pushes model results on accept; monitor pops on output handshake.
module tb_gradient_descent_array;

  localparam int LANES = 4;
  localparam int WIDTH = 16;
  localparam int FRAC  = 8;
  localparam int CNT_W = 16;
  localparam int DW    = LANES * WIDTH;

  logic             clk = 1'b0;
  logic             rst;
  logic             start_in;
  logic [CNT_W-1:0] num_updates_in;
  logic [WIDTH-1:0] lr_in;
  logic             valid_in;
  logic             ready_out;
  logic [DW-1:0]    w_old_in;
  logic [DW-1:0]    grad_in;
  logic             valid_out;
  logic             ready_in;
  logic [DW-1:0]    w_new_out;
  logic             last_out;
  logic             busy_out;
  logic             done_out;
`ifdef GD_SATURATE_EN
  logic [LANES-1:0] sat_flag_out;
`endif

  always #5 clk = ~clk;

  gradient_descent_array #(
    .LANES(LANES), .WIDTH(WIDTH), .FRAC(FRAC), .CNT_W(CNT_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start_in      (start_in),
    .num_updates_in(num_updates_in),
    .lr_in         (lr_in),
    .valid_in      (valid_in),
    .ready_out     (ready_out),
    .w_old_in      (w_old_in),
    .grad_in       (grad_in),
    .valid_out     (valid_out),
    .ready_in      (ready_in),
    .w_new_out     (w_new_out),
    .last_out      (last_out),
    .busy_out      (busy_out),
    .done_out      (done_out)
`ifdef GD_SATURATE_EN
    ,
    .sat_flag_out  (sat_flag_out)
`endif
  );

  typedef struct {
    logic [DW-1:0]    w;
    logic             last;
    logic [LANES-1:0] sat;
  } exp_t;

  exp_t          sbq[$];
  int            out_cyc[$];
  int            n_cmp = 0;
  int            n_bad = 0;
  int            done_cnt = 0;
  int            vout_cnt = 0;
  int            cyc = 0;
  logic [DW-1:0] last_w;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: real-valued rule W - floor(g*lr / 2^FRAC), then wrap or clamp.
  function automatic longint fit(input longint x, inout logic sat);
    longint hi, lo;
    hi = (longint'(1) <<< (WIDTH - 1)) - 1;
    lo = -(longint'(1) <<< (WIDTH - 1));
`ifdef GD_SATURATE_EN
    if (x > hi) begin
      sat = 1'b1;
      return hi;
    end
    if (x < lo) begin
      sat = 1'b1;
      return lo;
    end
    return x;
`else
    x = x - lo;
    x = x % (hi - lo + 1);
    if (x < 0) x = x + (hi - lo + 1);
    return x + lo;
`endif
  endfunction

  function automatic logic [WIDTH-1:0] ref_lane(
    input  logic [WIDTH-1:0] w,
    input  logic [WIDTH-1:0] g,
    input  logic [WIDTH-1:0] lr,
    output logic             sat
  );
    longint p, d;
    sat = 1'b0;
    p = longint'($signed(g)) * longint'($signed(lr));
    p = p >>> FRAC;
    p = fit(p, sat);
    d = longint'($signed(w)) - p;
    d = fit(d, sat);
    return d[WIDTH-1:0];
  endfunction

  // Monitor: pops the scoreboard on every output handshake.
  initial begin : monitor
    exp_t          e;
    logic          held;
    logic [DW-1:0] held_w;
    held = 1'b0;
    held_w = '0;
    forever begin
      @(negedge clk);
      #2;
      cyc++;
      if (done_out) done_cnt++;
      if (valid_out) vout_cnt++;
      if (valid_out && held) check("stall_hold", w_new_out, held_w);
      if (valid_out && ready_in) begin
        out_cyc.push_back(cyc);
        last_w = w_new_out;
        if (sbq.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_beat: got %h expected none", w_new_out);
        end else begin
          e = sbq.pop_front();
          check("w_new", w_new_out, e.w);
          check("last", last_out, e.last);
`ifdef GD_SATURATE_EN
          check("sat_flag", sat_flag_out, e.sat);
`endif
        end
      end
      held = valid_out && !ready_in;
      held_w = w_new_out;
    end
  end

  task automatic check_idle_zero(input string tag);
    check({tag, "_valid"}, valid_out, 0);
    check({tag, "_wnew"}, w_new_out, 0);
    check({tag, "_last"}, last_out, 0);
    check({tag, "_busy"}, busy_out, 0);
    check({tag, "_done"}, done_out, 0);
    check({tag, "_ready"}, ready_out, 0);
`ifdef GD_SATURATE_EN
    check({tag, "_sat"}, sat_flag_out, 0);
`endif
  endtask

  task automatic run_batch(
    input int               num,
    input logic [WIDTH-1:0] lr,
    input int               vpct,
    input int               rpct,
    input bit               fixed,
    input logic [WIDTH-1:0] fw,
    input logic [WIDTH-1:0] fg,
    input int               stall_at,
    input int               inject_at,
    input int               abort_at
  );
    int               acc = 0;
    int               it = 0;
    int               d0;
    bit               rdy_chk = 0;
    logic             s;
    logic [WIDTH-1:0] lw, lg;
    exp_t             e;
    d0 = done_cnt;
    @(negedge clk);
    start_in = 1'b1;
    num_updates_in = CNT_W'(num);
    lr_in = lr;
    @(negedge clk);
    forever begin
      if (abort_at >= 0 && acc == abort_at) begin
        rst = 1'b1;
        #1;
        check_idle_zero("abort");
        sbq.delete();
        valid_in = 1'b0;
        start_in = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_no_done", done_cnt - d0, 0);
        return;
      end
      start_in = (it == inject_at);
      num_updates_in = CNT_W'($urandom_range(1, 3));
      lr_in = start_in ? ~lr : WIDTH'($urandom);
      valid_in = (acc < num) && ($urandom_range(99) < vpct);
      for (int i = 0; i < LANES; i++) begin
        w_old_in[i*WIDTH +: WIDTH] = fixed ? fw : WIDTH'($urandom);
        grad_in[i*WIDTH +: WIDTH] = fixed ? fg : WIDTH'($urandom);
      end
      if (stall_at >= 0 && it >= stall_at && it < stall_at + 3)
        ready_in = 1'b0;
      else
        ready_in = ($urandom_range(99) < rpct);
      #1;
      if (valid_out && !ready_in) check("rdy_stall", ready_out, 0);
      if (acc == num && !rdy_chk) begin
        check("rdy_full", ready_out, 0);
        rdy_chk = 1;
      end
      if (valid_in && ready_out) begin
        for (int i = 0; i < LANES; i++) begin
          lw = w_old_in[i*WIDTH +: WIDTH];
          lg = grad_in[i*WIDTH +: WIDTH];
          e.w[i*WIDTH +: WIDTH] = ref_lane(lw, lg, lr, s);
          e.sat[i] = s;
        end
        e.last = (acc == num - 1);
        sbq.push_back(e);
        acc++;
      end
      if (done_cnt != d0) break;
      if (it > 2000) begin
        n_cmp++;
        n_bad++;
        $display("FAIL timeout: got %0d beats expected %0d", acc, num);
        break;
      end
      @(negedge clk);
      it++;
    end
    start_in = 1'b0;
    valid_in = 1'b0;
    ready_in = 1'b1;
    repeat (2) @(negedge clk);
    #3;
    check("done_once", done_cnt - d0, 1);
    check("busy_end", busy_out, 0);
    check("drained", sbq.size(), 0);
  endtask

  initial begin : main
    int v0;
    int d0;
    rst = 1'b1;
    start_in = 1'b0;
    num_updates_in = '0;
    lr_in = '0;
    valid_in = 1'b0;
    w_old_in = '0;
    grad_in = '0;
    ready_in = 1'b0;
    @(negedge clk);
    #1;
    check_idle_zero("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    ready_in = 1'b1;

    // Basic: 3.0 - 0.5*2.0 = 2.0
    run_batch(1, 16'h0080, 100, 100, 1, 16'h0300, 16'h0200, -1, -1, -1);
    check("basic_const", last_w, {4{16'h0200}});

    // Streaming, no backpressure: 8 beats in 8 consecutive cycles.
    out_cyc.delete();
    run_batch(8, 16'h0033, 100, 100, 0, '0, '0, -1, -1, -1);
    check("stream_n", out_cyc.size(), 8);
    if (out_cyc.size() == 8)
      check("stream_span", out_cyc[7] - out_cyc[0], 7);

    // Backpressure for 3 cycles mid-stream.
    out_cyc.delete();
    run_batch(6, 16'h0100, 100, 100, 0, '0, '0, 3, -1, -1);
    check("bp_n", out_cyc.size(), 6);

    // Overflow at the positive boundary.
    run_batch(2, 16'h0100, 100, 100, 1, 16'h7F00, 16'hFF00, -1, -1, -1);
`ifdef GD_SATURATE_EN
    check("ovf_const", last_w, {4{16'h7FFF}});
`else
    check("ovf_const", last_w, {4{16'h8000}});
`endif

    // Zero-length batch: done next cycle, no output beat.
    v0 = vout_cnt;
    d0 = done_cnt;
    @(negedge clk);
    start_in = 1'b1;
    num_updates_in = '0;
    lr_in = 16'h0123;
    @(negedge clk);
    start_in = 1'b0;
    #3;
    check("zero_done", done_out, 1);
    @(negedge clk);
    #3;
    check("zero_done_off", done_out, 0);
    check("zero_busy", busy_out, 0);
    check("zero_pulses", done_cnt - d0, 1);
    check("zero_no_valid", vout_cnt - v0, 0);

    // start_in during RUN is ignored (lr stays latched).
    run_batch(6, 16'h0040, 80, 100, 0, '0, '0, -1, 1, -1);

    // Reset after 3 of 8 beats, then a fresh batch.
    run_batch(8, 16'h0055, 100, 100, 0, '0, '0, -1, -1, 3);
    run_batch(4, 16'h00C0, 100, 100, 0, '0, '0, -1, -1, -1);

    // Randomised batches with random valid/ready gaps.
    for (int b = 0; b < 20; b++) begin
      run_batch($urandom_range(1, 10), WIDTH'($urandom),
                $urandom_range(40, 100), $urandom_range(40, 100),
                0, '0, '0, -1, -1, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/gradient_descent_array.md
Name: gradient_descent_array

Overview:
- Parametrised, pipelined SGD weight-update engine: computes W_new = W_old - lr * grad on LANES signed fixed-point lanes per beat.
- Runs a batch of num_updates beats per start command and signals completion.
- Sits between the weight/gradient buffers and the weight write-back path; replaces the single-lane, single-cycle update unit.
- Uses valid/ready handshakes on both sides, so it tolerates write-back backpressure.

Parameters:
- LANES, 4, number of parallel weight lanes per beat.
- WIDTH, 16, signed fixed-point word width for lr, weights and gradients.
- FRAC, 8, fractional bits (default format is Q8.8).
- CNT_W, 16, width of the batch beat counter.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- start_in  in  1  one-cycle pulse; begins a batch (honoured only in IDLE).
- num_updates_in  in  CNT_W  number of beats in the batch; latched on start.
- lr_in  in  WIDTH  learning rate; latched on start.
- valid_in  in  1  input beat valid.
- ready_out  out  1  input beat accepted when valid_in && ready_out.
- w_old_in  in  LANES*WIDTH  old weights; lane i at bits [i*WIDTH +: WIDTH].
- grad_in  in  LANES*WIDTH  gradients, same packing.
- valid_out  out  1  output beat valid.
- ready_in  in  1  downstream ready.
- w_new_out  out  LANES*WIDTH  updated weights, same packing.
- last_out  out  1  marks the final output beat of the batch; qualified by valid_out.
- busy_out  out  1  high whenever state != IDLE.
- done_out  out  1  one-cycle pulse when the batch has fully drained.

Behaviour:
- Reset values: all outputs 0; state IDLE; counters 0; pipeline valid bits 0. Latched lr = 0, latched num_updates = 0.
- Reset mid-batch aborts the batch; no done_out is produced.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE -> RUN on start_in: latch lr_in and num_updates_in; clear acc_cnt and out_cnt.
- IDLE -> DONE instead if start_in arrives with num_updates_in == 0.
- RUN -> DRAIN once acc_cnt reaches the latched count.
- DRAIN -> DONE when both pipeline stages are empty.
- DONE: done_out = 1 for exactly one cycle, then IDLE.
- start_in outside IDLE is ignored.
- Pipeline: two register stages.
  - Stage 1 registers per-lane product p = (grad * lr) >>> FRAC. The 2*WIDTH signed product is arithmetically shifted (floor) and reduced to WIDTH bits.
  - Stage 2 registers W_old - p, reduced to WIDTH bits. W_old travels alongside p through stage 1.
  - Latency is 2 cycles from an accepted beat to valid_out, with no stall.
- Stall: stall = valid_out && !ready_in. While stalled, both stages hold.
- A bubble in stage 2 may be filled from stage 1 even when stage 2's output is blocked.
- ready_out = (state == RUN) && (acc_cnt < count) && !stall. It is combinational from state and stall only and does not depend on valid_in.
- acc_cnt increments on each input handshake; out_cnt increments on each output handshake.
- last_out = valid_out && (out_cnt == count - 1).
- Throughput is one beat per cycle with no backpressure. Output data stays stable while valid_out && !ready_in.
- Non-saturating arithmetic (default): both the product reduction and the subtraction take the low WIDTH bits, i.e. two's-complement wrap.

Optional Feature:
- Macro: GD_SATURATE_EN.
- Defined:
  - The product reduction clamps to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
  - The subtraction is computed at WIDTH+1 bits and clamped to the same range.
  - Port sat_flag_out (out, LANES) is added: bit i pulses alongside the output beat when lane i clamped at either stage.
- Undefined: wrap behaviour as above; sat_flag_out is absent.

Decomposition:
- Package gd_pkg holds:
  - typedef gd_state_t (IDLE, RUN, DRAIN, DONE);
  - localparam PROD_W = 2*WIDTH;
  - the functions fxp_scale_mul() and fxp_sub() (each with a saturating variant).
- Sub-module gd_lane: one lane's two-stage datapath with enable, generated LANES times.
- The top level owns the FSM, counters and handshakes.

Test Plan (Q8.8, LANES=4):
- Basic update: lr=0x0080, all lanes grad=0x0200, W=0x0300, num=1, ready_in=1 -> w_new lanes=0x0200 two cycles after accept; last_out=1; done_out pulses once; busy_out drops.
- Streaming: num=8, continuous valid_in, ready_in=1 -> 8 outputs on consecutive cycles, in order; last_out only on the 8th; ready_out falls after the 8th accept.
- Backpressure: num=6; hold ready_in=0 for 3 cycles mid-stream -> no beat lost or duplicated; output data stable during the stall; ready_out low while stalled.
- Overflow: W=0x7F00, grad=0xFF00, lr=0x0100 -> 0x8000 without GD_SATURATE_EN; 0x7FFF with it, plus sat_flag_out=4'b1111.
- Edge cases: start with num=0 -> done_out pulses one cycle later and no valid_out appears; start_in asserted during RUN -> ignored and the latched lr is unchanged.
- Reset mid-batch: assert rst after 3 of 8 beats -> all outputs 0 at once, state IDLE, no done_out; a new batch afterwards runs correctly.
